// File: rtl/mul_seq_shiftadd.sv
// Iterative unsigned shift-and-add multiplier built around the fa_nbit adder.
// All vectors are [0:N-1] with bit 0 as the MSB, matching fa_nbit.

module fa_nbit #(
    parameter int N = 8
) (
    input  logic [0:N-1] A,
    input  logic [0:N-1] B,
    input  logic         cin,
    output logic [0:N-1] Sum,
    output logic         cout
);
    logic [0:N] total;

    assign total = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, cin};
    assign cout  = total[0];
    assign Sum   = total[1:N];
endmodule

// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | one add/shift iteration per cycle, WIDTH iterations
// DONE  | product valid, done pulses; start here reissues without a bubble
module mul_seq_shiftadd #(
    parameter int WIDTH = 32,
    parameter int CW    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [0:WIDTH-1]   a,
    input  logic [0:WIDTH-1]   b,
    output logic               busy,
    output logic               done,
    output logic [0:2*WIDTH-1] product
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [0:WIDTH-1] mcand;
    logic [0:WIDTH-1] hi;
    logic [0:WIDTH-1] lo;
    logic [0:WIDTH-1] addend;
    logic [0:WIDTH-1] sum;
    logic             cout;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             step;

    // lo[WIDTH-1] is the LSB: the multiplier bit consumed this iteration
    assign addend = lo[WIDTH-1] ? mcand : '0;

    fa_nbit #(.N(WIDTH)) u_add (
        .A    (hi),
        .B    (addend),
        .cin  (1'b0),
        .Sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                mcand <= a;
                hi    <= '0;
                lo    <= b;
                cnt   <= '0;
            end else if (step) begin
                // cout becomes the new MSB; the low sum bit shifts into lo
                hi  <= {cout, sum[0:WIDTH-2]};
                lo  <= {sum[WIDTH-1], lo[0:WIDTH-2]};
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign product = {hi, lo};
endmodule
